// File: rtl/alu_multicycle.sv
// Multi-cycle WIDTH-bit add/subtract unit: CHUNK bits per cycle through a registered carry chain.
// Optional saturation on signed overflow when ALU_SAT_EN is defined (default build wraps modulo 2^WIDTH).
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Operand latches and the partial sum being assembled chunk by chunk.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bn_q;
  logic [WIDTH-1:0] acc_q;
  logic             c_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] bn_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             c_next;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    a_chunk  = CHUNK'(a_q  >> (CHUNK * int'(cnt_q)));
    bn_chunk = CHUNK'(bn_q >> (CHUNK * int'(cnt_q)));
    {c_next, sum_chunk} = {1'b0, a_chunk} + {1'b0, bn_chunk} + {{CHUNK{1'b0}}, c_q};

    acc_d = acc_q;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CNT_W'(k)) acc_d[k*CHUNK +: CHUNK] = sum_chunk;
    end

    // Only meaningful on the last chunk, which is the only time it is consumed.
    ovf_d = (a_q[WIDTH-1] == bn_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);

    res_d = acc_d;
`ifdef ALU_SAT_EN
    if (ovf_d) begin
      res_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: the operand/partial-sum registers have no reset: they are always loaded on accept
  // before being read, so a reset would only add routing to a wide datapath.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q   <= a;
      bn_q  <= b ^ {WIDTH{sub}};
      c_q   <= sub;
      acc_q <= '0;
    end else if (state_q == BUSY) begin
      c_q   <= c_next;
      acc_q <= acc_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= BUSY;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            cnt_q    <= '0;
            result   <= res_d;
            carry    <= c_next;
            zero     <= ~|res_d;
            overflow <= ovf_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
